// File: rtl/dom2_pkg.sv
// rtl/dom2_pkg.sv - shared constants and FSM state for the dom2 gadget scheduler
package dom2_pkg;

  localparam int N_SHARES = 3;
  localparam int REFRESH_W = 3;
  localparam logic [15:0] DEFAULT_TAPS = 16'hB400;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

endpackage

// File: rtl/dom2_lfsr.sv
// rtl/dom2_lfsr.sv - Fibonacci LFSR advancing three bits per step, zero seed guarded
module dom2_lfsr import dom2_pkg::*; #(
  parameter int W = 16,
  parameter logic [W-1:0] SEED = W'(16'hACE1),
  parameter logic [W-1:0] TAPS = W'(DEFAULT_TAPS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 step,
  output logic [REFRESH_W-1:0] rnd
);

  // An all-zero state would lock the register forever.
  localparam logic [W-1:0] SEED_SAFE = (SEED == '0) ? W'(1) : SEED;

  logic [W-1:0] state;

  function automatic logic [W-1:0] step1(input logic [W-1:0] s);
    return {s[W-2:0], ^(s & TAPS)};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED_SAFE;
    end else if (step) begin
      state <= step1(step1(step1(state)));
    end
  end

  assign rnd = state[REFRESH_W-1:0];

endmodule

// File: rtl/dom2_sched.sv
// rtl/dom2_sched.sv - round-robin scheduler sharing one 3-share DOM AND gadget
module dom2_sched import dom2_pkg::*; #(
  parameter int N_REQ = 2,
  parameter int LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED = LFSR_W'(16'hACE1),
  parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(DEFAULT_TAPS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_SHARES*N_REQ-1:0]    req_a,
  input  logic [N_SHARES*N_REQ-1:0]    req_b,
  output logic [N_REQ-1:0]             req_ready,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [$clog2(N_REQ)-1:0]     resp_id,
  output logic [N_SHARES-1:0]          resp_c,
  output logic [1:0]                   g_is0,
  output logic [1:0]                   g_is1,
  output logic [1:0]                   g_is2,
  output logic [REFRESH_W-1:0]         g_refreshing,
  input  logic [N_SHARES-1:0]          g_os
);

  localparam int ID_W = $clog2(N_REQ);

  state_t state, state_nxt;
  logic [ID_W-1:0] rr_ptr, grant_id;
  logic grant_any;
  logic [N_SHARES-1:0] a_sel, b_sel;
  logic [REFRESH_W-1:0] lfsr_bits;

  dom2_lfsr #(.W(LFSR_W), .SEED(SEED), .TAPS(LFSR_TAPS)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .step (state == ISSUE),
    .rnd  (lfsr_bits)
  );

  // Second pass overrides the first, so the lowest index above the pointer wins,
  // falling back to the lowest index at or below it.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    a_sel     = '0;
    b_sel     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && i <= int'(rr_ptr)) begin
        grant_any = 1'b1;
        grant_id  = ID_W'(i);
        a_sel     = req_a[N_SHARES*i +: N_SHARES];
        b_sel     = req_b[N_SHARES*i +: N_SHARES];
      end
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && i > int'(rr_ptr)) begin
        grant_any = 1'b1;
        grant_id  = ID_W'(i);
        a_sel     = req_a[N_SHARES*i +: N_SHARES];
        b_sel     = req_b[N_SHARES*i +: N_SHARES];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_any && !rst) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant_any) state_nxt = ISSUE;
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
    endcase
  end

  // Gadget inputs are registered so they are non-zero only for the ISSUE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= ID_W'(N_REQ - 1);
      resp_valid   <= 1'b0;
      resp_id      <= '0;
      resp_c       <= '0;
      g_is0        <= '0;
      g_is1        <= '0;
      g_is2        <= '0;
      g_refreshing <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (grant_any) begin
            rr_ptr       <= grant_id;
            resp_id      <= grant_id;
            g_is0        <= {b_sel[0], a_sel[0]};
            g_is1        <= {b_sel[1], a_sel[1]};
            g_is2        <= {b_sel[2], a_sel[2]};
            g_refreshing <= lfsr_bits;
          end
        end
        ISSUE: begin
          g_is0        <= '0;
          g_is1        <= '0;
          g_is2        <= '0;
          g_refreshing <= '0;
        end
        CAPTURE: begin
          resp_c     <= g_os;
          resp_valid <= 1'b1;
        end
        RESP: begin
          if (resp_ready) resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dom2_sched.sv
// tb/tb_dom2_sched.sv - directed self-checking bench for dom2_sched with a DOM AND gadget model
module tb_dom2_sched;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] req_valid, req_ready;
  logic [5:0] req_a, req_b;
  logic resp_valid, resp_ready;
  logic [0:0] resp_id;
  logic [2:0] resp_c, g_refreshing;
  logic [2:0] g_os = 3'b000;
  logic [1:0] g_is0, g_is1, g_is2;

  logic [1:0] z_req_ready, z_is0, z_is1, z_is2;
  logic z_resp_valid;
  logic [0:0] z_resp_id;
  logic [2:0] z_resp_c, z_refreshing;

  int n_assert = 0;
  int n_fail = 0;
  logic [15:0] m_lfsr = 16'hACE1;
  logic [15:0] hist[$];
  logic first_issue = 1'b1;
  logic [2:0] ra, rb;
  int id;

  always #5 clk = ~clk;

  dom2_sched u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_c(resp_c), .g_is0(g_is0), .g_is1(g_is1), .g_is2(g_is2),
    .g_refreshing(g_refreshing), .g_os(g_os)
  );

  dom2_sched #(.SEED(16'h0000)) u_z (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(z_req_ready), .resp_valid(z_resp_valid), .resp_ready(resp_ready),
    .resp_id(z_resp_id), .resp_c(z_resp_c), .g_is0(z_is0), .g_is1(z_is1), .g_is2(z_is2),
    .g_refreshing(z_refreshing), .g_os(3'b000)
  );

  function automatic logic [2:0] dom_and(input logic [2:0] a, input logic [2:0] b, input logic [2:0] r);
    logic [2:0] c;
    c[0] = (a[0] & b[0]) ^ (a[0] & b[1]) ^ r[0] ^ (a[0] & b[2]) ^ r[1];
    c[1] = (a[1] & b[1]) ^ (a[1] & b[0]) ^ r[0] ^ (a[1] & b[2]) ^ r[2];
    c[2] = (a[2] & b[2]) ^ (a[2] & b[0]) ^ r[1] ^ (a[2] & b[1]) ^ r[2];
    return c;
  endfunction

  always @(posedge clk)
    g_os <= dom_and({g_is2[0], g_is1[0], g_is0[0]}, {g_is2[1], g_is1[1], g_is0[1]}, g_refreshing);

  function automatic logic [15:0] model_step3(input logic [15:0] s);
    logic fb;
    for (int n = 0; n < 3; n++) begin
      fb = s[15] ^ s[13] ^ s[12] ^ s[10];
      s  = {s[14:0], fb};
    end
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic txn(input string tag, input int gid, input logic [2:0] a, input logic [2:0] b, input int hold);
    logic [2:0] c_keep;
    logic rep;
    logic prod;
    prod = (^a) & (^b);
    #1;
    chk({tag, "_rdy"}, 32'(req_ready), 32'(1 << gid));
    chk({tag, "_gis_idle"}, 32'({g_is2, g_is1, g_is0, g_refreshing}), 32'(0));
    @(negedge clk); #1;
    chk({tag, "_gis0"}, 32'(g_is0), 32'({b[0], a[0]}));
    chk({tag, "_gis1"}, 32'(g_is1), 32'({b[1], a[1]}));
    chk({tag, "_gis2"}, 32'(g_is2), 32'({b[2], a[2]}));
    chk({tag, "_refresh"}, 32'(g_refreshing), 32'(m_lfsr[2:0]));
    chk({tag, "_rdy_issue"}, 32'(req_ready), 32'(0));
    rep = 1'b0;
    foreach (hist[j]) if (hist[j] == u_dut.u_lfsr.state) rep = 1'b1;
    chk({tag, "_lfsr_fresh"}, 32'(rep), 32'(0));
    hist.push_back(u_dut.u_lfsr.state);
    if (hist.size() > 19) void'(hist.pop_front());
    chk({tag, "_z_lfsr_nonzero"}, 32'(u_z.u_lfsr.state != 16'h0), 32'(1));
    if (first_issue) begin
      chk({tag, "_z_first_refresh"}, 32'(z_refreshing), 32'(3'b001));
      first_issue = 1'b0;
    end
    m_lfsr = model_step3(m_lfsr);
    @(negedge clk); #1;
    chk({tag, "_gis_capture"}, 32'({g_is2, g_is1, g_is0, g_refreshing}), 32'(0));
    chk({tag, "_valid_capture"}, 32'(resp_valid), 32'(0));
    resp_ready = (hold == 0);
    @(negedge clk); #1;
    chk({tag, "_valid"}, 32'(resp_valid), 32'(1));
    chk({tag, "_id"}, 32'(resp_id), 32'(gid));
    chk({tag, "_product"}, 32'(^resp_c), 32'(prod));
    chk({tag, "_gis_resp"}, 32'({g_is2, g_is1, g_is0, g_refreshing}), 32'(0));
    c_keep = resp_c;
    for (int h = 1; h < hold; h++) begin
      @(negedge clk); #1;
      chk({tag, "_hold_valid"}, 32'(resp_valid), 32'(1));
      chk({tag, "_hold_c"}, 32'(resp_c), 32'(c_keep));
      chk({tag, "_hold_id"}, 32'(resp_id), 32'(gid));
      chk({tag, "_hold_rdy"}, 32'(req_ready), 32'(0));
    end
    resp_ready = 1'b1;
    @(negedge clk); #1;
    chk({tag, "_done"}, 32'(resp_valid), 32'(0));
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_resp_valid", 32'(resp_valid), 32'(0));
    chk("reset_outputs", 32'({resp_id, resp_c, g_is2, g_is1, g_is0, g_refreshing}), 32'(0));
    chk("reset_req_ready", 32'(req_ready), 32'(0));
    rst = 1'b0;

    req_valid = 2'b01; req_a = 6'b000_100; req_b = 6'b000_010;
    txn("single", 0, 3'b100, 3'b010, 0);

    req_valid = 2'b11; req_a = {3'b001, 3'b001}; req_b = {3'b100, 3'b110};
    txn("hold", 1, 3'b001, 3'b100, 5);
    txn("alt0", 0, 3'b001, 3'b110, 0);
    txn("alt1", 1, 3'b001, 3'b100, 0);
    txn("alt2", 0, 3'b001, 3'b110, 0);
    txn("alt3", 1, 3'b001, 3'b100, 0);

    for (int i = 0; i < 64; i++) begin
      id = i % 2;
      ra = 3'(i);
      rb = 3'(i >> 3);
      req_a = '0; req_b = '0;
      req_a[3*id +: 3] = ra;
      req_b[3*id +: 3] = rb;
      req_valid = 2'(1 << id);
      txn($sformatf("exh%0d", i), id, ra, rb, int'($urandom_range(0, 2)));
    end

    req_valid = 2'b01; req_a = 6'b000_011; req_b = 6'b000_001;
    #1;
    chk("midrst_rdy", 32'(req_ready), 32'(1));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; req_valid = '0;
    @(negedge clk); #1;
    chk("midrst_resp_valid", 32'(resp_valid), 32'(0));
    chk("midrst_outputs", 32'({resp_id, resp_c, g_is2, g_is1, g_is0, g_refreshing}), 32'(0));
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("midrst_no_resp", 32'(resp_valid), 32'(0));
    end
    m_lfsr = 16'hACE1;
    hist.delete();
    first_issue = 1'b1;
    req_valid = 2'b11; req_a = {3'b010, 3'b111}; req_b = {3'b011, 3'b100};
    txn("post_rst", 0, 3'b111, 3'b100, 0);
    req_valid = '0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
